// File: rtl/hazard_stall_controller.sv
// Hazard/stall sequencer for the 5-stage core: tracks in-flight destinations,
// raises RAW/load-use stalls, freezes on SRAM wait, squashes on taken branches.
module hazard_stall_controller #(
  parameter int REG_ADDR_LEN = 4,
  parameter int MAX_WAIT     = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    forwarding_enable,
  input  logic                    id_valid,
  input  logic [REG_ADDR_LEN-1:0] id_src1,
  input  logic [REG_ADDR_LEN-1:0] id_src2,
  input  logic                    id_src1_used,
  input  logic                    id_src2_used,
  input  logic [REG_ADDR_LEN-1:0] id_dest,
  input  logic                    id_wb_en,
  input  logic                    id_mem_read,
  input  logic                    id_mem_write,
  input  logic                    branch_taken,
  input  logic                    mem_ready,
  input  logic                    stat_clear,
  output logic                    hazard_stall,
  output logic                    pipeline_freeze,
  output logic                    flush,
  output logic                    mem_timeout,
  output logic [15:0]             stall_count
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic                    valid;
    logic [REG_ADDR_LEN-1:0] dest;
    logic                    wb_en;
    logic                    mem_read;
    logic                    mem_write;
  } slot_t;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  // WB never participates in a hazard (register file writes mid-cycle),
  // so only the EXE and MEM slots are stored.
  slot_t    exe_slot, mem_slot;
  state_t   state, state_nxt;
  logic [WCW-1:0] wait_cnt;
  logic     mem_busy, raw;

  function automatic logic match(input slot_t s, input logic [REG_ADDR_LEN-1:0] src);
    return s.valid & s.wb_en & (s.dest == src);
  endfunction

  assign mem_busy = mem_slot.valid & (mem_slot.mem_read | mem_slot.mem_write) & ~mem_ready;

  always_comb begin
    raw = 1'b0;
    if (forwarding_enable) begin
      raw = exe_slot.mem_read &
            ((id_src1_used & match(exe_slot, id_src1)) |
             (id_src2_used & match(exe_slot, id_src2)));
    end else begin
      raw = (id_src1_used & (match(exe_slot, id_src1) | match(mem_slot, id_src1))) |
            (id_src2_used & (match(exe_slot, id_src2) | match(mem_slot, id_src2)));
    end
  end

  // FSM next state and freeze
  always_comb begin
    state_nxt       = state;
    pipeline_freeze = 1'b0;
    case (state)
      RUN: begin
        pipeline_freeze = mem_busy;
        if (mem_busy) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        pipeline_freeze = ~mem_ready;
        if (mem_ready) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) pipeline_freeze = 1'b0;
  end

  assign flush        = ~rst & ~pipeline_freeze & branch_taken;
  assign hazard_stall = ~rst & ~pipeline_freeze & ~flush & id_valid & raw;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exe_slot <= '0;
      mem_slot <= '0;
    end else if (!pipeline_freeze) begin
      mem_slot <= exe_slot;
      exe_slot.valid     <= id_valid & ~hazard_stall & ~flush;
      exe_slot.dest      <= id_dest;
      exe_slot.wb_en     <= id_wb_en;
      exe_slot.mem_read  <= id_mem_read;
      exe_slot.mem_write <= id_mem_write;
    end
  end

  // Wait counter runs over consecutive frozen cycles and saturates at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (pipeline_freeze) begin
      if (wait_cnt != WCW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else if (stat_clear) begin
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      if (pipeline_freeze && wait_cnt >= WCW'(MAX_WAIT - 1)) mem_timeout <= 1'b1;
      if ((hazard_stall || pipeline_freeze) && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Randomized + directed bench for hazard_stall_controller; expected outputs come
// from an instruction-level pipeline model and are checked through a queue.
module tb_hazard_stall_controller;
  localparam int RL = 4;
  localparam int MW = 15;

  logic          clk = 0;
  logic          rst, forwarding_enable, id_valid, id_src1_used, id_src2_used;
  logic [RL-1:0] id_src1, id_src2, id_dest;
  logic          id_wb_en, id_mem_read, id_mem_write, branch_taken, mem_ready, stat_clear;
  logic          hazard_stall, pipeline_freeze, flush, mem_timeout;
  logic [15:0]   stall_count;

  hazard_stall_controller #(.REG_ADDR_LEN(RL), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .forwarding_enable(forwarding_enable), .id_valid(id_valid),
    .id_src1(id_src1), .id_src2(id_src2), .id_src1_used(id_src1_used),
    .id_src2_used(id_src2_used), .id_dest(id_dest), .id_wb_en(id_wb_en),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .stat_clear(stat_clear), .hazard_stall(hazard_stall),
    .pipeline_freeze(pipeline_freeze), .flush(flush), .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; bit [RL-1:0] d; bit wb, mr, mw;} ins_t;
  typedef struct {bit hz, frz, fl, to; int cnt;} exp_t;

  exp_t q[$];
  ins_t pipe[2];          // [0]=EXE, [1]=MEM; WB never causes a hazard
  int   m_cnt, m_run;
  bit   m_to, last_hz, last_frz;
  int   n_chk, n_pass;

  function automatic bit writes(ins_t e, bit [RL-1:0] s);
    return e.v && e.wb && e.d == s;
  endfunction

  task automatic chk(string name, int act, int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("hazard_stall", hazard_stall, e.hz);
      chk("pipeline_freeze", pipeline_freeze, e.frz);
      chk("flush", flush, e.fl);
      chk("mem_timeout", mem_timeout, e.to);
      chk("stall_count", stall_count, e.cnt);
    end
  end

  // One clock: predict this cycle's outputs, then retire the cycle in the model.
  task automatic step();
    exp_t e;
    bit raw;
    raw = 0;
    e.frz = !rst && pipe[1].v && (pipe[1].mr || pipe[1].mw) && !mem_ready;
    e.fl  = !rst && !e.frz && branch_taken;
    for (int k = 0; k < 2; k++) begin
      bit [RL-1:0] s;
      bit u;
      s = (k == 0) ? id_src1 : id_src2;
      u = (k == 0) ? id_src1_used : id_src2_used;
      if (u) begin
        if (forwarding_enable) raw |= pipe[0].mr && writes(pipe[0], s);
        else                   raw |= writes(pipe[0], s) || writes(pipe[1], s);
      end
    end
    e.hz  = !rst && !e.frz && !e.fl && id_valid && raw;
    e.to  = m_to;
    e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    if (rst) begin
      pipe[0] = '{default:0}; pipe[1] = '{default:0};
      m_cnt = 0; m_run = 0; m_to = 0;
    end else begin
      if (!e.frz) begin
        pipe[1] = pipe[0];
        pipe[0].v  = id_valid && !e.hz && !e.fl;
        pipe[0].d  = id_dest; pipe[0].wb = id_wb_en;
        pipe[0].mr = id_mem_read; pipe[0].mw = id_mem_write;
      end
      m_run = e.frz ? m_run + 1 : 0;
      if (stat_clear) begin
        m_cnt = 0; m_to = 0;
      end else begin
        if ((e.hz || e.frz) && m_cnt < 65535) m_cnt++;
        if (e.frz && m_run >= MW) m_to = 1;
      end
    end
    last_hz = e.hz; last_frz = e.frz;
    #1;
  endtask

  task automatic issue(bit v, int d, int s1, int s2, bit u1, bit u2, bit wb, bit mr, bit mw);
    id_valid = v; id_dest = RL'(d); id_src1 = RL'(s1); id_src2 = RL'(s2);
    id_src1_used = u1; id_src2_used = u2; id_wb_en = wb; id_mem_read = mr; id_mem_write = mw;
  endtask

  task automatic nops(int n);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (n) step();
  endtask

  task automatic hold_while_stalled();
    step();
    while (last_hz || last_frz) step();
  endtask

  initial begin
    rst = 1; forwarding_enable = 1; branch_taken = 0; mem_ready = 1; stat_clear = 0;
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0);
    pipe[0] = '{default:0}; pipe[1] = '{default:0};
    m_cnt = 0; m_run = 0; m_to = 0; n_chk = 0; n_pass = 0;
    @(posedge clk); #1;
    step(); step();
    rst = 0;

    // load-use with forwarding: one stall cycle
    issue(1, 3, 0, 0, 0, 0, 1, 1, 0); step();
    issue(1, 4, 3, 1, 1, 1, 1, 0, 0); hold_while_stalled();
    nops(3);
    // plain RAW: two stalls without forwarding, none with it
    forwarding_enable = 0;
    issue(1, 2, 0, 1, 1, 1, 1, 0, 0); step();
    issue(1, 5, 2, 2, 1, 1, 1, 0, 0); hold_while_stalled();
    nops(3);
    forwarding_enable = 1;
    issue(1, 2, 0, 1, 1, 1, 1, 0, 0); step();
    issue(1, 5, 2, 2, 1, 1, 1, 0, 0); hold_while_stalled();
    nops(3);
    // store waits 3 cycles in MEM
    issue(1, 0, 1, 2, 1, 1, 0, 0, 1); step();
    nops(1);
    mem_ready = 0; step(); step(); step();
    mem_ready = 1; nops(3);
    // timeout after 15 frozen cycles, then clear
    issue(1, 0, 1, 2, 1, 1, 0, 0, 1); step();
    nops(1);
    mem_ready = 0; repeat (20) step();
    mem_ready = 1; nops(2);
    stat_clear = 1; step(); stat_clear = 0; nops(2);
    // branch beats a load-use stall
    issue(1, 3, 0, 0, 0, 0, 1, 1, 0); step();
    issue(1, 4, 3, 1, 1, 1, 1, 0, 0); branch_taken = 1; step();
    branch_taken = 0; nops(3);
    // branch held during freeze only flushes once unfrozen
    issue(1, 0, 1, 2, 1, 1, 0, 0, 1); step();
    nops(1);
    mem_ready = 0; branch_taken = 1; step(); step(); step();
    mem_ready = 1; step();
    branch_taken = 0; nops(3);
    // reset in the middle of a wait
    issue(1, 0, 1, 2, 1, 1, 0, 1, 0); step();
    nops(1);
    mem_ready = 0; step(); step();
    rst = 1; step();
    rst = 0; mem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      issue(1, 8 + i, i, i + 1, 1, 1, 1, 0, 0); step();
    end
    nops(2);

    // random traffic; ID and a pending branch are held while stalled/frozen
    for (int i = 0; i < 3000; i++) begin
      forwarding_enable = (i / 500) % 2 == 0;
      stat_clear = ($urandom_range(0, 199) == 0);
      mem_ready  = ($urandom_range(0, 3) != 0);
      if (!(last_hz || last_frz)) begin
        issue($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      end
      if (!last_frz) branch_taken = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 0; stat_clear = 0; branch_taken = 0; mem_ready = 1;
    nops(2);
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
